// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants, scheduler FSM encodings and the
// look-ahead line helper used by the line-buffer scheduler.
package vga_timing_pkg;

    localparam logic [9:0] VGA_H_ACTIVE = 10'd640;
    localparam logic [9:0] VGA_H_TOTAL  = 10'd800;
    localparam logic [9:0] VGA_V_ACTIVE = 10'd480;
    localparam logic [9:0] VGA_V_TOTAL  = 10'd525;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_RENDER = 2'd2;

    // Line two ahead of y, wrapping at the end of the frame.
    function automatic logic [9:0] line_ahead2(input logic [9:0] y, input logic [9:0] v_total);
        logic [9:0] wrap_at;
        wrap_at = v_total - 10'd2;
        if (y >= wrap_at) begin
            line_ahead2 = y - wrap_at;
        end else begin
            line_ahead2 = y + 10'd2;
        end
    endfunction

endpackage

// File: rtl/vga_event_detect.sv
// Horizontal-blank and line-start event detection from the pixel column.
// Each event is one clk wide because x_q catches up with x on the next clk.
module vga_event_detect
    import vga_timing_pkg::*;
#(
    parameter logic [9:0] H_ACTIVE = VGA_H_ACTIVE,
    parameter logic [9:0] H_TOTAL  = VGA_H_TOTAL
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [9:0] x_i,
    output logic       hb_evt_o,
    output logic       ls_evt_o
);

    logic [9:0] x_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q <= 10'd0;
        end else begin
            x_q <= x_i;
        end
    end

    assign hb_evt_o = (x_i == H_ACTIVE) && (x_q == H_ACTIVE - 10'd1);
    assign ls_evt_o = (x_i == 10'd0) && (x_q == H_TOTAL - 10'd1);

endmodule

// File: rtl/line_job_scheduler.sv
// Ping-pong line-buffer render scheduler: issues a job for the line two ahead
// at each horizontal blank, tracks buffer readiness and flags missed lines.
module line_job_scheduler
    import vga_timing_pkg::*;
#(
    parameter logic [9:0]  H_ACTIVE = VGA_H_ACTIVE,
    parameter logic [9:0]  H_TOTAL  = VGA_H_TOTAL,
    parameter logic [9:0]  V_ACTIVE = VGA_V_ACTIVE,
    parameter logic [9:0]  V_TOTAL  = VGA_V_TOTAL,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    output logic             job_valid,
    input  logic             job_ready,
    output logic [8:0]       job_line,
    output logic             job_buf,
    output logic             job_abort,
    input  logic             line_done,
    output logic             rd_buf,
    output logic             line_fill,
    output logic             cfg_latch,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic             busy
);

    logic             hb_evt;
    logic             ls_evt;
    logic [1:0]       state_q, state_d;
    logic             job_valid_q, job_valid_d;
    logic [8:0]       job_line_q, job_line_d;
    logic             job_buf_q, job_buf_d;
    logic             job_abort_q, job_abort_d;
    logic [1:0]       buf_valid_q, buf_valid_d;
    logic [1:0]       miss_mark_q, miss_mark_d;
    logic             line_fill_q, line_fill_d;
    logic             cfg_latch_q, cfg_latch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic [9:0]       tgt_s;
    logic             y_vis_s, create_s, finish_s, abort_s, cnt_inc_s;

    vga_event_detect #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL)
    ) u_evt (
        .clk_i    (clk),
        .reset_i  (reset),
        .x_i      (x),
        .hb_evt_o (hb_evt),
        .ls_evt_o (ls_evt)
    );

    assign tgt_s    = line_ahead2(y, V_TOTAL);
    assign y_vis_s  = (y < V_ACTIVE);
    assign create_s = hb_evt && enable && (tgt_s < V_ACTIVE);
    // A finishing render beats a same-cycle blank, so it is never aborted.
    assign finish_s = (state_q == ST_RENDER) && line_done;
    assign abort_s  = hb_evt && !finish_s && ((state_q == ST_ISSUE) || (state_q == ST_RENDER));

    // Next-state for the job FSM, buffer readiness, deadline flag and counter.
    always_comb begin
        state_d     = state_q;
        job_valid_d = job_valid_q;
        job_line_d  = job_line_q;
        job_buf_d   = job_buf_q;
        job_abort_d = abort_s;
        buf_valid_d = buf_valid_q;
        miss_mark_d = miss_mark_q;
        line_fill_d = line_fill_q;
        cfg_latch_d = ls_evt && (y == V_ACTIVE);

        if (hb_evt && y_vis_s) begin
            buf_valid_d[y[0]] = 1'b0;
        end else begin
            buf_valid_d = buf_valid_q;
        end
        if (finish_s) begin
            buf_valid_d[job_buf_q] = 1'b1;
        end else begin
            buf_valid_d = buf_valid_d;
        end
        // The abort already counted this line; the deadline check must not.
        if (abort_s) begin
            miss_mark_d[job_buf_q] = 1'b1;
        end else begin
            miss_mark_d = miss_mark_q;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (job_ready && !hb_evt) begin
                    state_d     = ST_RENDER;
                    job_valid_d = 1'b0;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RENDER: begin
                state_d = finish_s ? ST_IDLE : ST_RENDER;
            end
            default: begin
                state_d     = ST_IDLE;
                job_valid_d = 1'b0;
            end
        endcase

        if (create_s) begin
            state_d     = ST_ISSUE;
            job_valid_d = 1'b1;
            job_line_d  = tgt_s[8:0];
            job_buf_d   = tgt_s[0];
        end else if (abort_s) begin
            state_d     = ST_IDLE;
            job_valid_d = 1'b0;
        end else begin
            job_line_d = job_line_d;
        end

        if (ls_evt && y_vis_s) begin
            line_fill_d       = ~buf_valid_q[y[0]];
            miss_mark_d[y[0]] = 1'b0;
        end else if (ls_evt) begin
            line_fill_d = 1'b0;
        end else begin
            line_fill_d = line_fill_q;
        end

        cnt_inc_s = abort_s || (ls_evt && y_vis_s && !buf_valid_q[y[0]] && !miss_mark_q[y[0]]);
        cnt_d     = (cnt_inc_s && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State and output registers; reset drops any job without an abort pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            job_valid_q <= 1'b0;
            job_line_q  <= 9'd0;
            job_buf_q   <= 1'b0;
            job_abort_q <= 1'b0;
            buf_valid_q <= 2'b00;
            miss_mark_q <= 2'b00;
            line_fill_q <= 1'b0;
            cfg_latch_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_valid_q <= job_valid_d;
            job_line_q  <= job_line_d;
            job_buf_q   <= job_buf_d;
            job_abort_q <= job_abort_d;
            buf_valid_q <= buf_valid_d;
            miss_mark_q <= miss_mark_d;
            line_fill_q <= line_fill_d;
            cfg_latch_q <= cfg_latch_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign job_valid    = job_valid_q;
    assign job_line     = job_line_q;
    assign job_buf      = job_buf_q;
    assign job_abort    = job_abort_q;
    assign rd_buf       = y[0];
    assign line_fill    = line_fill_q;
    assign cfg_latch    = cfg_latch_q;
    assign underrun_cnt = cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_line_job_scheduler.sv
// Directed bench for line_job_scheduler: compressed scanline timing with a
// small rasterizer model that answers accepted jobs after a fixed delay.
module tb_line_job_scheduler;

    localparam int HOLD       = 52;
    localparam int RAST_DELAY = 50;

    logic       clk;
    logic       reset, enable, job_ready, line_done;
    logic [9:0] x, y;
    logic       job_valid, job_buf, job_abort, rd_buf, line_fill, cfg_latch, busy;
    logic [8:0] job_line;
    logic [7:0] underrun_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int withhold  = -1;
    bit done_req  = 1'b0;
    int rast_cnt  = 0;
    int cur_line  = -1;
    int cfg_cnt   = 0;
    int bufmis    = 0;
    int acc_q[$];

    line_job_scheduler #(.CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .x            (x),
        .y            (y),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_line     (job_line),
        .job_buf      (job_buf),
        .job_abort    (job_abort),
        .line_done    (line_done),
        .rd_buf       (rd_buf),
        .line_fill    (line_fill),
        .cfg_latch    (cfg_latch),
        .underrun_cnt (underrun_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rasterizer model and monitor: samples just before each rising edge.
    initial begin
        line_done = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            line_done = 1'b0;
            if (reset) begin
                rast_cnt = 0;
            end else begin
                if (job_abort) rast_cnt = 0;
                if (rast_cnt > 0) begin
                    rast_cnt--;
                    if (rast_cnt == 0 && cur_line != withhold) line_done = 1'b1;
                end
                if (done_req) line_done = 1'b1;
                if (job_valid && job_ready) begin
                    acc_q.push_back(int'(job_line));
                    if (job_buf !== job_line[0]) bufmis++;
                    cur_line = int'(job_line);
                    rast_cnt = RAST_DELAY;
                end
                if (cfg_latch) cfg_cnt++;
            end
        end
    end

    task automatic drive(input logic [9:0] xv, input logic [9:0] yv);
        @(negedge clk);
        x = xv;
        y = yv;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ls_edge(input logic [9:0] yv);
        drive(10'd799, y);
        drive(10'd0, yv);
        tick(1);
    endtask

    task automatic hb_edge(input bit with_done);
        drive(10'd639, y);
        drive(10'd640, y);
        done_req = with_done;
        tick(1);
        done_req = 1'b0;
    endtask

    task automatic run_line(input int yy);
        ls_edge(10'(yy));
        hb_edge(1'b0);
        tick(HOLD);
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; job_ready = 1'b1; x = 10'd0; y = 10'd1;
        tick(3);
        check_cnt++;
        if ({job_valid, job_abort, job_buf, line_fill, cfg_latch, busy} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000", {job_valid, job_abort, job_buf, line_fill, cfg_latch, busy});
        else pass_cnt++;
        check_cnt++;
        if (job_line !== 9'd0) $display("FAIL reset_line: got %0d expected 0", job_line); else pass_cnt++;
        check_cnt++;
        if (underrun_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", underrun_cnt); else pass_cnt++;
        check_cnt++;
        if (rd_buf !== 1'b1) $display("FAIL rd_buf: got %0b expected 1", rd_buf); else pass_cnt++;
        reset = 1'b0;
        y = 10'd0;
        tick(1);
    endtask

    task automatic test_nominal_frame;
        int fills, acc0, cfg0, mis0, bad;
        fills = 0; acc0 = acc_q.size(); cfg0 = cfg_cnt; mis0 = bufmis; bad = 0;
        for (int i = 0; i < 525; i++) begin
            int yy;
            yy = (480 + i) % 525;
            ls_edge(10'(yy));
            if (line_fill !== 1'b0) fills++;
            if (yy == 480) begin
                check_cnt++;
                if (cfg_latch !== 1'b1) $display("FAIL cfg_pulse: got %0b expected 1", cfg_latch); else pass_cnt++;
            end
            hb_edge(1'b0);
            if (yy == 523) begin
                check_cnt++;
                if (job_valid !== 1'b1 || job_line !== 9'd0 || job_buf !== 1'b0)
                    $display("FAIL first_job: got valid=%0b line=%0d buf=%0b expected 1/0/0", job_valid, job_line, job_buf);
                else pass_cnt++;
            end
            if (yy == 524) begin
                check_cnt++;
                if (job_line !== 9'd1) $display("FAIL wrap_job: got %0d expected 1", job_line); else pass_cnt++;
            end
            tick(HOLD);
        end
        check_cnt++;
        if (fills != 0) $display("FAIL nominal_fill: got %0d fill lines expected 0", fills); else pass_cnt++;
        check_cnt++;
        if (acc_q.size() - acc0 != 480) $display("FAIL job_count: got %0d expected 480", acc_q.size() - acc0); else pass_cnt++;
        for (int k = 0; k < 480 && acc0 + k < acc_q.size(); k++)
            if (acc_q[acc0 + k] != k) bad++;
        check_cnt++;
        if (bad != 0) $display("FAIL job_order: got %0d out-of-order jobs expected 0", bad); else pass_cnt++;
        check_cnt++;
        if (bufmis != mis0) $display("FAIL job_buf: got %0d mismatches expected 0", bufmis - mis0); else pass_cnt++;
        check_cnt++;
        if (cfg_cnt - cfg0 != 1) $display("FAIL cfg_count: got %0d expected 1", cfg_cnt - cfg0); else pass_cnt++;
        check_cnt++;
        if (underrun_cnt !== 8'd0) $display("FAIL nominal_cnt: got %0d expected 0", underrun_cnt); else pass_cnt++;
    endtask

    task automatic test_missed_line;
        for (int i = 0; i < 54; i++) run_line((480 + i) % 525);
        withhold = 10;
        run_line(8);
        ls_edge(10'd9);
        hb_edge(1'b0);
        check_cnt++;
        if (job_abort !== 1'b1) $display("FAIL abort_pulse: got %0b expected 1", job_abort); else pass_cnt++;
        check_cnt++;
        if (job_valid !== 1'b1 || job_line !== 9'd11)
            $display("FAIL abort_reissue: got valid=%0b line=%0d expected 1/11", job_valid, job_line);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (job_abort !== 1'b0) $display("FAIL abort_width: got %0b expected 0", job_abort); else pass_cnt++;
        tick(HOLD - 1);
        ls_edge(10'd10);
        check_cnt++;
        if (line_fill !== 1'b1) $display("FAIL miss_fill_start: got %0b expected 1", line_fill); else pass_cnt++;
        hb_edge(1'b0);
        tick(HOLD);
        check_cnt++;
        if (line_fill !== 1'b1) $display("FAIL miss_fill_end: got %0b expected 1", line_fill); else pass_cnt++;
        check_cnt++;
        if (underrun_cnt !== 8'd1) $display("FAIL miss_count_once: got %0d expected 1", underrun_cnt); else pass_cnt++;
        withhold = -1;
        ls_edge(10'd11);
        check_cnt++;
        if (line_fill !== 1'b0) $display("FAIL recover_fill: got %0b expected 0", line_fill); else pass_cnt++;
        hb_edge(1'b0);
        tick(HOLD);
    endtask

    task automatic test_done_with_blank;
        for (int yy = 12; yy < 19; yy++) run_line(yy);
        withhold = 21;
        run_line(19);
        ls_edge(10'd20);
        hb_edge(1'b1);
        check_cnt++;
        if (job_abort !== 1'b0) $display("FAIL same_clk_abort: got %0b expected 0", job_abort); else pass_cnt++;
        check_cnt++;
        if (job_valid !== 1'b1 || job_line !== 9'd22)
            $display("FAIL same_clk_issue: got valid=%0b line=%0d expected 1/22", job_valid, job_line);
        else pass_cnt++;
        check_cnt++;
        if (underrun_cnt !== 8'd1) $display("FAIL same_clk_cnt: got %0d expected 1", underrun_cnt); else pass_cnt++;
        tick(HOLD);
        withhold = -1;
        ls_edge(10'd21);
        check_cnt++;
        if (line_fill !== 1'b0) $display("FAIL same_clk_valid: got %0b expected 0", line_fill); else pass_cnt++;
        hb_edge(1'b0);
        tick(HOLD);
    endtask

    task automatic test_enable_gap;
        int fills_in, fills_out, issued;
        fills_in = 0; fills_out = 0; issued = 0;
        for (int yy = 22; yy < 98; yy++) run_line(yy);
        for (int yy = 98; yy <= 110; yy++) begin
            ls_edge(10'(yy));
            if (yy >= 100 && yy <= 109) begin
                if (line_fill === 1'b1) fills_in++;
            end else if (line_fill !== 1'b0) begin
                fills_out++;
            end
            enable = (yy >= 98 && yy <= 107) ? 1'b0 : 1'b1;
            hb_edge(1'b0);
            if (yy <= 107 && job_valid !== 1'b0) issued++;
            if (yy == 108) begin
                check_cnt++;
                if (job_valid !== 1'b1 || job_line !== 9'd110)
                    $display("FAIL enable_resume: got valid=%0b line=%0d expected 1/110", job_valid, job_line);
                else pass_cnt++;
            end
            tick(HOLD);
        end
        check_cnt++;
        if (issued != 0) $display("FAIL enable_no_issue: got %0d jobs expected 0", issued); else pass_cnt++;
        check_cnt++;
        if (fills_in != 10) $display("FAIL enable_fill: got %0d lines expected 10", fills_in); else pass_cnt++;
        check_cnt++;
        if (fills_out != 0) $display("FAIL enable_fill_edge: got %0d lines expected 0", fills_out); else pass_cnt++;
        check_cnt++;
        if (underrun_cnt !== 8'd11) $display("FAIL enable_cnt: got %0d expected 11", underrun_cnt); else pass_cnt++;
    endtask

    task automatic test_ready_stall;
        for (int yy = 111; yy < 120; yy++) run_line(yy);
        ls_edge(10'd120);
        job_ready = 1'b0;
        hb_edge(1'b0);
        tick(HOLD);
        check_cnt++;
        if (job_valid !== 1'b1 || job_line !== 9'd122)
            $display("FAIL stall_hold: got valid=%0b line=%0d expected 1/122", job_valid, job_line);
        else pass_cnt++;
        ls_edge(10'd121);
        check_cnt++;
        if (job_valid !== 1'b1 || job_line !== 9'd122 || line_fill !== 1'b0)
            $display("FAIL stall_hold_ls: got valid=%0b line=%0d fill=%0b expected 1/122/0", job_valid, job_line, line_fill);
        else pass_cnt++;
        hb_edge(1'b0);
        check_cnt++;
        if (job_abort !== 1'b1 || job_valid !== 1'b1 || job_line !== 9'd123)
            $display("FAIL stall_abort: got abort=%0b valid=%0b line=%0d expected 1/1/123", job_abort, job_valid, job_line);
        else pass_cnt++;
        job_ready = 1'b1;
        tick(HOLD);
        ls_edge(10'd122);
        check_cnt++;
        if (line_fill !== 1'b1 || underrun_cnt !== 8'd12)
            $display("FAIL stall_miss: got fill=%0b cnt=%0d expected 1/12", line_fill, underrun_cnt);
        else pass_cnt++;
        hb_edge(1'b0);
        tick(HOLD);
        ls_edge(10'd123);
        check_cnt++;
        if (line_fill !== 1'b0) $display("FAIL stall_recover: got %0b expected 0", line_fill); else pass_cnt++;
        hb_edge(1'b0);
        tick(HOLD);
    endtask

    task automatic test_reset_mid_render;
        ls_edge(10'd124);
        hb_edge(1'b0);
        tick(10);
        check_cnt++;
        if (busy !== 1'b1) $display("FAIL render_busy: got %0b expected 1", busy); else pass_cnt++;
        reset = 1'b1;
        tick(1);
        check_cnt++;
        if ({job_valid, job_abort, job_buf, line_fill, cfg_latch, busy} !== 6'b0 || job_line !== 9'd0 || underrun_cnt !== 8'd0)
            $display("FAIL midreset_outputs: got flags=%b line=%0d cnt=%0d expected 0/0/0",
                     {job_valid, job_abort, job_buf, line_fill, cfg_latch, busy}, job_line, underrun_cnt);
        else pass_cnt++;
        reset = 1'b0;
        tick(2);
        check_cnt++;
        if (job_valid !== 1'b0 || job_abort !== 1'b0)
            $display("FAIL midreset_quiet: got valid=%0b abort=%0b expected 0/0", job_valid, job_abort);
        else pass_cnt++;
        ls_edge(10'd125);
        check_cnt++;
        if (line_fill !== 1'b1 || underrun_cnt !== 8'd1)
            $display("FAIL midreset_miss: got fill=%0b cnt=%0d expected 1/1", line_fill, underrun_cnt);
        else pass_cnt++;
        hb_edge(1'b0);
        check_cnt++;
        if (job_valid !== 1'b1 || job_line !== 9'd127)
            $display("FAIL midreset_issue: got valid=%0b line=%0d expected 1/127", job_valid, job_line);
        else pass_cnt++;
        tick(HOLD);
    endtask

    task automatic test_saturation;
        reset = 1'b1;
        enable = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ls_edge(10'(i));
            if (i == 99) begin
                check_cnt++;
                if (underrun_cnt !== 8'd100) $display("FAIL sat_mid: got %0d expected 100", underrun_cnt); else pass_cnt++;
            end
            if (i == 254) begin
                check_cnt++;
                if (underrun_cnt !== 8'd255) $display("FAIL sat_reach: got %0d expected 255", underrun_cnt); else pass_cnt++;
            end
        end
        check_cnt++;
        if (underrun_cnt !== 8'd255 || line_fill !== 1'b1)
            $display("FAIL sat_hold: got cnt=%0d fill=%0b expected 255/1", underrun_cnt, line_fill);
        else pass_cnt++;
        enable = 1'b1;
    endtask

    initial begin
        test_reset;
        test_nominal_frame;
        test_missed_line;
        test_done_with_blank;
        test_enable_gap;
        test_ready_stall;
        test_reset_mid_render;
        test_saturation;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/line_job_scheduler.md
Name: line_job_scheduler

Overview:
- Scanline render scheduler for the ping-pong line-buffer path between the rasterizer and VGA scanout.
- Watches the 640x480 timing counters (x, y). At each horizontal-blank start it issues a render job for the line two ahead into the buffer just freed.
- Tracks per-buffer readiness and flags lines whose job missed the display deadline, so scanout substitutes a fill colour.
- Pulses a per-frame config-latch strobe so the renderer can update frame parameters during vertical blank.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- CNT_W, 8, underrun counter width

Ports:
- clk  in  1  system clock (100 MHz); x/y advance at most once per 4 clocks
- reset  in  1  synchronous, active-high
- enable  in  1  allow job issue; when low, no new jobs are issued
- x  in  10  current pixel column from the timing generator
- y  in  10  current line from the timing generator
- job_valid  out  1  job offered to the rasterizer
- job_ready  in  1  rasterizer accepts the job
- job_line  out  9  target line 0..479
- job_buf  out  1  target line buffer (= job_line[0])
- job_abort  out  1  one-cycle pulse: outstanding job cancelled
- line_done  in  1  one-cycle pulse: current job finished
- rd_buf  out  1  buffer scanout reads (= y[0])
- line_fill  out  1  current line invalid; scanout outputs fill colour
- cfg_latch  out  1  one-cycle pulse at vertical-blank start
- underrun_cnt  out  CNT_W  saturating count of missed lines
- busy  out  1  job outstanding (ISSUE or RENDER)

Behaviour:
- Reset values: all outputs 0, state IDLE, buf_valid[1:0]=0, registered x_q=0, underrun_cnt=0. Reset mid-job drops the job silently: no abort pulse.
- Event detection uses a registered copy x_q, updated every clk.
  - hb_evt = (x==H_ACTIVE) && (x_q==H_ACTIVE-1).
  - ls_evt = (x==0) && (x_q==H_TOTAL-1).
  - Each event is exactly one clk wide.
- Target line on hb_evt: T = (y+2) mod V_TOTAL, e.g. y=523 gives T=0 and y=524 gives T=1. A job is created only if T < V_ACTIVE and enable=1.
- On hb_evt with y < V_ACTIVE: clear buf_valid[y[0]], since that buffer has been fully displayed. The clear happens in the same cycle as any new issue into it.
- FSM states:
  - IDLE: on hb_evt with a job to create, latch job_line=T and job_buf=T[0], go to ISSUE.
  - ISSUE: job_valid=1, with job_line and job_buf held stable. On job_ready, go to RENDER. job_valid drops the cycle after the handshake.
  - RENDER: on line_done, set buf_valid[job_buf]=1 and go to IDLE.
  - hb_evt while in ISSUE or RENDER: pulse job_abort and count an underrun. Do not set buf_valid for the aborted job. If a new job is to be created, go directly to ISSUE with the new target; otherwise go to IDLE.
- Same-cycle line_done and hb_evt in RENDER: done wins. Set buf_valid, no abort, then issue the new job (enter ISSUE).
- line_done in IDLE or ISSUE is ignored. job_ready outside ISSUE is ignored.
- Deadline check on ls_evt with y < V_ACTIVE:
  - line_fill <= ~buf_valid[y[0]].
  - If the buffer is invalid, increment underrun_cnt, saturating at all-ones.
  - An abort and a deadline miss caused by the same job count once. The abort path marks the line so ls_evt does not recount it.
- On ls_evt with y >= V_ACTIVE: line_fill <= 0. line_fill holds from one ls_evt to the next.
- cfg_latch pulses 1 clk on the clk where y first equals V_ACTIVE (y==480 && x==0 && x_q==H_TOTAL-1).
- enable low: no new jobs; an in-flight job completes normally. Lines then miss and fill, and are counted.
- rd_buf is combinational from y[0]. All other outputs are registered.

Decomposition:
- Shared package vga_timing_pkg holds H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL and the event-detect helper constants; it is reused by the timing generator and scanout.
- One natural sub-module, vga_event_detect: x_q register plus hb_evt and ls_evt.
- The FSM, buffer-valid tracking and counter stay in the top module.

Test Plan:
- Nominal frame, job_ready tied 1, line_done 50 clks after accept:
  - jobs for lines 0..479 in order with job_buf=line[0];
  - first job (line 0) issued at y=523,x=640;
  - line_fill=0 throughout; underrun_cnt=0;
  - cfg_latch pulses once per frame at y=480.
- line_done withheld for line 10:
  - job_abort pulses at hb_evt of y=9;
  - line_fill=1 for all of y=10;
  - underrun_cnt=1 (not 2);
  - job for line 11 issued in the same cycle.
- line_done and hb_evt in the same clk: no abort, buf_valid set, next job issued, underrun_cnt unchanged.
- enable=0 for lines 100..109: no jobs issued; those lines show line_fill=1; underrun_cnt=10. Toggle enable back: issue resumes at the next hb_evt.
- job_ready held 0 for a whole line: job_valid stays high with a stable job_line; abort fires at the next hb_evt and valid moves to the new line.
- reset asserted mid-RENDER: next clk all outputs 0, state IDLE, no job_abort; first job after release is issued at the next qualifying hb_evt.
- 300 forced misses: underrun_cnt saturates at 255.
